inst_rom_loader: RTL and testbench

Instruction-memory responder for the core's fetch port: answers `rom_ce`/`rom_addr` with the instruction word in the same cycle, as the core's IF stage expects. It also contains a byte-serial boot loader. The loader fills the memory from a valid/ready byte stream and holds the core in reset while a load is in progress. It sits beside `openmips` in the SoC top, between the fetch port and a UART/debug byte source.

---
 rtl/inst_rom_loader_pkg.sv | 20 ++
 rtl/inst_rom_loader_mem_array.sv | 28 ++
 rtl/inst_rom_loader.sv | 142 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared loader types and constants: FSM encoding, stream field widths and
// the length-header acceptance rule.
package inst_rom_loader_pkg;

  localparam int LD_LEN_W  = 16;
  localparam int LD_BYTE_W = 8;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_LEN_HI = 2'd1,
    LD_LEN_LO = 2'd2,
    LD_DATA   = 2'd3
  } ld_state_e;

  // A header is usable only if it names between 1 and 2^aw words.
  function automatic logic len_ok(input logic [LD_LEN_W-1:0] len, input int aw);
    return (len != '0) && ({1'b0, len} <= (17'd1 << aw));
  endfunction

endpackage

// File: rtl/inst_rom_loader_mem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port,
// no reset so contents survive core and loader resets.
module inst_mem_array
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle fetch: the IF stage expects the word combinationally.
  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Fetch-port instruction memory with a byte-serial boot loader that fills
// the array from a valid/ready stream and holds the core while loading.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [DATA_WIDTH-1:0] rom_data_o,
  input  logic                  ld_start_i,
  input  logic [LD_BYTE_W-1:0]  ld_byte_i,
  input  logic                  ld_byte_valid_i,
  output logic                  ld_byte_ready_o,
  output logic                  core_hold_o,
  output logic                  ld_busy_o,
  output logic                  ld_done_o,
  output logic                  ld_err_o
);

  ld_state_e             state_reg, state_next;
  logic [LD_LEN_W-1:0]   len_reg, len_next;
  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [1:0]            bcnt_reg, bcnt_next;
  logic [23:0]           asm_reg, asm_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  logic                  accept;
  logic                  last_word;
  logic [LD_LEN_W-1:0]   len_hdr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_addr_bits;

  assign accept    = ld_byte_valid_i && (state_reg != LD_IDLE);
  assign len_hdr   = {len_reg[15:8], ld_byte_i};
  assign last_word = (LD_LEN_W'(wptr_reg) == (len_reg - LD_LEN_W'(1)));
  assign mem_wdata = {asm_reg, ld_byte_i};

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    wptr_next  = wptr_reg;
    bcnt_next  = bcnt_reg;
    asm_next   = asm_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      LD_IDLE: begin
        if (ld_start_i) begin
          state_next = LD_LEN_HI;
          len_next   = '0;
          wptr_next  = '0;
          bcnt_next  = '0;
          asm_next   = '0;
        end
      end
      LD_LEN_HI: begin
        if (accept) begin
          len_next[15:8] = ld_byte_i;
          state_next     = LD_LEN_LO;
        end
      end
      LD_LEN_LO: begin
        if (accept) begin
          len_next = len_hdr;
          if (len_ok(len_hdr, ADDR_WIDTH)) begin
            state_next = LD_DATA;
          end else begin
            state_next = LD_IDLE;
            err_next   = 1'b1;
          end
        end
      end
      LD_DATA: begin
        if (accept) begin
          bcnt_next = bcnt_reg + 2'd1;
          asm_next  = {asm_reg[15:0], ld_byte_i};
          // Fourth byte completes the word; the earlier three are in asm_reg.
          if (bcnt_reg == 2'd3) begin
            mem_we    = 1'b1;
            wptr_next = wptr_reg + 1'b1;
            if (last_word) begin
              state_next = LD_IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end
      default: state_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= LD_IDLE;
      len_reg   <= '0;
      wptr_reg  <= '0;
      bcnt_reg  <= '0;
      asm_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      wptr_reg  <= wptr_next;
      bcnt_reg  <= bcnt_next;
      asm_reg   <= asm_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign ld_byte_ready_o = (state_reg != LD_IDLE);
  assign core_hold_o     = (state_reg != LD_IDLE);
  assign ld_busy_o       = (state_reg != LD_IDLE);
  assign ld_done_o       = done_reg;
  assign ld_err_o        = err_reg;

  inst_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_reg),
    .wdata (mem_wdata),
    .raddr (rom_addr_i[ADDR_WIDTH+1:2]),
    .rdata (mem_rdata)
  );

  // Byte offset and bits above the word index alias onto the same word.
  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};
  assign rom_data_o       = rom_ce_i ? mem_rdata : '0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: fetch vectors from a table applied after
// each load phase, plus hand sequences for handshake, abort and collision cases.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = '0;
  logic [31:0] rom_data_o;
  logic        ld_start_i = 1'b0;
  logic [7:0]  ld_byte_i = '0;
  logic        ld_byte_valid_i = 1'b0;
  logic        ld_byte_ready_o;
  logic        core_hold_o;
  logic        ld_busy_o;
  logic        ld_done_o;
  logic        ld_err_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          phase;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  fetch_vec_t  vecs[$];
  logic [7:0]  stream[$];

  localparam logic [31:0] W0 = 32'hDEADBEEF, W1 = 32'h01234567,
                          W2 = 32'hA5A55A5A, W3 = 32'h0F0F00F0;

  inst_rom_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_i        (rom_ce_i),
    .rom_addr_i      (rom_addr_i),
    .rom_data_o      (rom_data_o),
    .ld_start_i      (ld_start_i),
    .ld_byte_i       (ld_byte_i),
    .ld_byte_valid_i (ld_byte_valid_i),
    .ld_byte_ready_o (ld_byte_ready_o),
    .core_hold_o     (core_hold_o),
    .ld_busy_o       (ld_busy_o),
    .ld_done_o       (ld_done_o),
    .ld_err_o        (ld_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int p, input logic ce, input logic [31:0] a, input logic [31:0] e);
    fetch_vec_t v;
    v.phase = p; v.ce = ce; v.addr = a; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic apply_phase(input int p);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        @(negedge clk);
        rom_ce_i   = vecs[i].ce;
        rom_addr_i = vecs[i].addr;
        #1;
        chk($sformatf("fetch p%0d ce%0d a%h", p, vecs[i].ce, vecs[i].addr), rom_data_o, vecs[i].exp);
        $display("fetch p%0d ce=%0d addr=%h data=%h", p, rom_ce_i, rom_addr_i, rom_data_o);
      end
    end
    rom_ce_i = 1'b0;
  endtask

  task automatic push_hdr(input logic [15:0] n);
    stream.delete();
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
  endtask

  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  // Start a load and stream the bytes with valid held high.
  task automatic run_stream(input bit expect_err, input bit finish, input bit watch_en,
                            input logic [31:0] old_w, input logic [31:0] new_w);
    @(negedge clk);
    ld_start_i = 1'b1;
    for (int i = 0; i < stream.size(); i++) begin
      @(negedge clk);
      ld_start_i = 1'b0;
      chk($sformatf("hold b%0d", i), {31'b0, core_hold_o}, 32'd1);
      chk($sformatf("ready b%0d", i), {31'b0, ld_byte_ready_o}, 32'd1);
      ld_byte_valid_i = 1'b1;
      ld_byte_i       = stream[i];
      if (watch_en && i == stream.size() - 1) begin
        #1;
        chk("collide_old", rom_data_o, old_w);
      end
    end
    if (!finish) return;
    @(negedge clk);
    ld_byte_valid_i = 1'b0;
    ld_byte_i       = '0;
    chk("done_pulse", {31'b0, ld_done_o}, {31'b0, !expect_err});
    chk("err_pulse", {31'b0, ld_err_o}, {31'b0, expect_err});
    chk("hold_end", {31'b0, core_hold_o}, 32'd0);
    chk("busy_end", {31'b0, ld_busy_o}, 32'd0);
    if (watch_en) chk("collide_new", rom_data_o, new_w);
    @(negedge clk);
    chk("done_clear", {31'b0, ld_done_o}, 32'd0);
    chk("err_clear", {31'b0, ld_err_o}, 32'd0);
    $display("load n_bytes=%0d err=%0d done/err checked", stream.size(), expect_err);
  endtask

  initial begin
    add_vec(0, 0, 32'h0000_0000, 32'h0);
    add_vec(0, 0, 32'h0000_0008, 32'h0);
    add_vec(0, 0, 32'hFFFF_FFFC, 32'h0);
    add_vec(1, 1, 32'h0000_0000, 32'hC0DE_0000);
    add_vec(1, 1, 32'h0000_0004, 32'hC0DE_0001);
    add_vec(1, 1, 32'h0000_0FFC, 32'hC0DE_03FF);
    add_vec(1, 1, 32'h0000_1000, 32'hC0DE_0000);
    add_vec(2, 1, 32'h0000_0008, W2);
    add_vec(2, 1, 32'h0000_000B, W2);
    add_vec(2, 1, 32'h0000_0000, W0);
    add_vec(2, 1, 32'h0000_0004, W1);
    add_vec(2, 1, 32'h0000_000C, W3);
    add_vec(2, 1, 32'h0000_1008, W2);
    add_vec(2, 0, 32'h0000_0008, 32'h0);
    add_vec(2, 1, 32'h0000_0010, 32'hC0DE_0004);
    add_vec(2, 1, 32'hFFFF_FFFC, 32'hC0DE_03FF);
    add_vec(3, 1, 32'h0000_0000, 32'h3401_1100);
    add_vec(3, 1, 32'h0000_0004, 32'h3402_0020);
    add_vec(3, 1, 32'h0000_0008, W2);
    add_vec(4, 1, 32'h0000_0000, 32'h3401_1100);
    add_vec(4, 1, 32'h0000_0004, 32'h3402_0020);
    add_vec(5, 1, 32'h0000_0000, 32'hCAFE_F00D);
    add_vec(5, 1, 32'h0000_0004, 32'h1234_5678);
    add_vec(5, 1, 32'h0000_0008, W2);
    add_vec(6, 1, 32'h0000_0000, 32'h1122_3344);
    add_vec(6, 1, 32'h0000_0004, 32'h1234_5678);
    add_vec(6, 1, 32'h0000_0008, W2);
    add_vec(7, 1, 32'h0000_0000, 32'h9988_7766);
    add_vec(7, 1, 32'h0000_0004, 32'h1234_5678);
    add_vec(8, 1, 32'h0000_0000, 32'hAAAA_0001);
    add_vec(8, 1, 32'h0000_0004, 32'hBBBB_0002);

    // Reset values and gated fetch while in reset
    #1;
    chk("rst_ready", {31'b0, ld_byte_ready_o}, 32'd0);
    chk("rst_hold", {31'b0, core_hold_o}, 32'd0);
    chk("rst_busy", {31'b0, ld_busy_o}, 32'd0);
    chk("rst_done", {31'b0, ld_done_o}, 32'd0);
    chk("rst_err", {31'b0, ld_err_o}, 32'd0);
    apply_phase(0);
    @(negedge clk);
    rst = 1'b1;

    // Largest legal image: 1024 words
    push_hdr(16'h0400);
    for (int i = 0; i < 1024; i++) push_word(32'hC0DE_0000 | i);
    run_stream(0, 1, 0, '0, '0);
    apply_phase(1);

    push_hdr(16'd4);
    push_word(W0); push_word(W1); push_word(W2); push_word(W3);
    run_stream(0, 1, 0, '0, '0);
    apply_phase(2);

    push_hdr(16'd2);
    push_word(32'h3401_1100); push_word(32'h3402_0020);
    run_stream(0, 1, 0, '0, '0);
    apply_phase(3);

    // Rejected headers: zero length and one word too many
    push_hdr(16'h0000);
    run_stream(1, 1, 0, '0, '0);
    push_hdr(16'h0401);
    run_stream(1, 1, 0, '0, '0);
    apply_phase(4);

    // Valid toggling with start pulses while busy
    push_hdr(16'd2);
    push_word(32'hCAFE_F00D); push_word(32'h1234_5678);
    @(negedge clk);
    ld_start_i = 1'b1;
    for (int i = 0; i < stream.size(); i++) begin
      @(negedge clk);
      chk($sformatf("tog_busy b%0d", i), {31'b0, ld_busy_o}, 32'd1);
      ld_start_i = 1'b0;
      ld_byte_valid_i = 1'b1;
      ld_byte_i = stream[i];
      if (i < stream.size() - 1) begin
        @(negedge clk);
        ld_byte_valid_i = 1'b0;
        ld_byte_i = 8'hEE;
        ld_start_i = 1'b1;
      end
    end
    @(negedge clk);
    ld_byte_valid_i = 1'b0;
    ld_start_i = 1'b0;
    chk("tog_done", {31'b0, ld_done_o}, 32'd1);
    chk("tog_hold", {31'b0, core_hold_o}, 32'd0);
    $display("toggle load finished done=%0d", ld_done_o);
    apply_phase(5);

    // Reset after 1.5 words of a 3-word load
    push_hdr(16'd3);
    push_word(32'h1122_3344);
    stream.push_back(8'h55);
    stream.push_back(8'h66);
    run_stream(0, 0, 0, '0, '0);
    @(negedge clk);
    ld_byte_valid_i = 1'b0;
    chk("abort_busy_before", {31'b0, ld_busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_ready", {31'b0, ld_byte_ready_o}, 32'd0);
    chk("abort_hold", {31'b0, core_hold_o}, 32'd0);
    chk("abort_busy", {31'b0, ld_busy_o}, 32'd0);
    chk("abort_done", {31'b0, ld_done_o}, 32'd0);
    $display("reset mid-load: hold=%0d busy=%0d", core_hold_o, ld_busy_o);
    @(negedge clk);
    rst = 1'b1;
    apply_phase(6);

    push_hdr(16'd1);
    push_word(32'h9988_7766);
    run_stream(0, 1, 0, '0, '0);
    apply_phase(7);

    // Fetch word 1 while it is being written
    rom_ce_i = 1'b1;
    rom_addr_i = 32'h0000_0004;
    push_hdr(16'd2);
    push_word(32'hAAAA_0001); push_word(32'hBBBB_0002);
    run_stream(0, 1, 1, 32'h1234_5678, 32'hBBBB_0002);
    apply_phase(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
